// File: rtl/dtcm_ctrl_pkg.sv
// Shared widths and types for the data-TCM responder and its response buffer.
// Single home for XLEN / DTCM address widths so the sub-blocks never redeclare them.
package dtcm_ctrl_pkg;

    localparam int XLEN            = 32;
    localparam int XLEN_BYTES      = XLEN / 8;
    localparam int DTCM_ADDR_WIDTH = 16;
    localparam int DTCM_RAM_AW     = DTCM_ADDR_WIDTH - 2;
    localparam int DTCM_RAM_DW     = XLEN;
    localparam int RSP_DEPTH       = 2;

    typedef logic [XLEN-1:0]            word_t;
    typedef logic [XLEN_BYTES-1:0]      wmask_t;
    typedef logic [DTCM_ADDR_WIDTH-1:0] byte_addr_t;
    typedef logic [DTCM_RAM_AW-1:0]     ram_addr_t;
    typedef logic [1:0]                 rsp_cnt_t;

    // Byte address to SRAM word address; the two lane-select bits are dropped.
    function automatic ram_addr_t word_addr(input byte_addr_t a);
        return a[DTCM_ADDR_WIDTH-1:2];
    endfunction

endpackage

// File: rtl/dtcm_rsp_fifo.sv
// Two-entry response buffer; accepts push and pop in the same cycle, including
// a push into a full buffer when the head is leaving on that edge.
module dtcm_rsp_fifo
    import dtcm_ctrl_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  logic     pop,
    input  word_t    din,
    output word_t    dout,
    output logic     full,
    output logic     empty,
    output rsp_cnt_t count
);

    word_t mem [RSP_DEPTH];
    logic  wptr;
    logic  rptr;
    logic  push_en;
    logic  pop_en;

    assign full    = (count == rsp_cnt_t'(RSP_DEPTH));
    assign empty   = (count == '0);
    assign pop_en  = pop & ~empty;
    assign push_en = push & (~full | pop_en);
    assign dout    = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            count <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_en) begin
                mem[wptr] <= din;
                wptr      <= ~wptr;
            end
            if (pop_en) begin
                rptr <= ~rptr;
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dtcm_ctrl.sv
// Data-TCM responder: LSU command/response handshake in front of a 1-cycle
// single-port byte-writable SRAM, with a 2-entry buffer for response stalls.
module dtcm_ctrl
    import dtcm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       dtcm_cmd_valid,
    output logic       dtcm_cmd_ready,
    input  logic       dtcm_cmd_read,
    input  byte_addr_t dtcm_cmd_addr,
    input  word_t      dtcm_cmd_wdata,
    input  wmask_t     dtcm_cmd_wmask,
    output logic       dtcm_rsp_valid,
    input  logic       dtcm_rsp_ready,
    output word_t      dtcm_rsp_rdata,
    output logic       ram_cs,
    output logic       ram_we,
    output ram_addr_t  ram_addr,
    output wmask_t     ram_wem,
    output word_t      ram_din,
    input  word_t      ram_dout
);

    // Handshakes: a beat transfers on a rising edge where valid & ready are both
    // high. Valid never waits on ready; cmd_ready depends only on local credit
    // state, never combinationally on dtcm_rsp_ready.

    logic     acc;
    logic     infl;
    logic     infl_rd;
    word_t    dout_eff;
    word_t    fifo_head;
    logic     fifo_push;
    logic     fifo_pop;
    logic     fifo_full;
    logic     fifo_empty;
    rsp_cnt_t fcnt;
    rsp_cnt_t used;

    // Credit counts the in-flight stage as an occupied buffer slot.
    assign used           = fcnt + {1'b0, infl};
    assign dtcm_cmd_ready = ~rst & ~fifo_full & (used < 2'd2);
    assign acc            = dtcm_cmd_valid & dtcm_cmd_ready;

    assign ram_cs   = acc;
    assign ram_we   = acc & ~dtcm_cmd_read;
    assign ram_addr = word_addr(dtcm_cmd_addr);
    assign ram_wem  = dtcm_cmd_wmask;
    assign ram_din  = dtcm_cmd_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            infl    <= 1'b0;
            infl_rd <= 1'b0;
        end else begin
            infl    <= acc;
            infl_rd <= acc & dtcm_cmd_read;
        end
    end

    // Write responses carry zero data so stale SRAM output never leaks out.
    assign dout_eff = infl_rd ? ram_dout : '0;

    always_comb begin
        dtcm_rsp_valid = 1'b0;
        dtcm_rsp_rdata = '0;
        fifo_push      = 1'b0;
        fifo_pop       = 1'b0;
        if (fifo_empty) begin
            dtcm_rsp_valid = infl;
            dtcm_rsp_rdata = dout_eff;
            fifo_push      = infl & ~dtcm_rsp_ready;
        end else begin
            // Older buffered responses go first; the stage result queues behind them.
            dtcm_rsp_valid = 1'b1;
            dtcm_rsp_rdata = fifo_head;
            fifo_pop       = dtcm_rsp_ready;
            fifo_push      = infl;
        end
    end

    dtcm_rsp_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (dout_eff),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fcnt)
    );

endmodule

// File: tb/tb_dtcm_ctrl.sv
// Bench for dtcm_ctrl: SRAM model, reference memory scoreboard, directed
// latency/stall/reset scenarios and a random back-pressure run.
module tb_dtcm_ctrl;
    import dtcm_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       dtcm_cmd_valid;
    logic       dtcm_cmd_ready;
    logic       dtcm_cmd_read;
    byte_addr_t dtcm_cmd_addr;
    word_t      dtcm_cmd_wdata;
    wmask_t     dtcm_cmd_wmask;
    logic       dtcm_rsp_valid;
    logic       dtcm_rsp_ready;
    word_t      dtcm_rsp_rdata;
    logic       ram_cs;
    logic       ram_we;
    ram_addr_t  ram_addr;
    wmask_t     ram_wem;
    word_t      ram_din;
    word_t      ram_dout;

    int tests = 0;
    int fails = 0;
    int acc_cnt = 0;
    int rsp_cnt = 0;
    int dropped = 0;
    int cyc = 0;
    int max_fcnt = 0;
    logic rand_rdy = 1'b0;
    logic [XLEN-1:0] exp_q[$];

    word_t     sram    [0:(1<<DTCM_RAM_AW)-1];
    word_t     ref_mem [0:(1<<DTCM_RAM_AW)-1];
    ram_addr_t acc_w;

    dtcm_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .dtcm_cmd_valid (dtcm_cmd_valid),
        .dtcm_cmd_ready (dtcm_cmd_ready),
        .dtcm_cmd_read  (dtcm_cmd_read),
        .dtcm_cmd_addr  (dtcm_cmd_addr),
        .dtcm_cmd_wdata (dtcm_cmd_wdata),
        .dtcm_cmd_wmask (dtcm_cmd_wmask),
        .dtcm_rsp_valid (dtcm_rsp_valid),
        .dtcm_rsp_ready (dtcm_rsp_ready),
        .dtcm_rsp_rdata (dtcm_rsp_rdata),
        .ram_cs         (ram_cs),
        .ram_we         (ram_we),
        .ram_addr       (ram_addr),
        .ram_wem        (ram_wem),
        .ram_din        (ram_din),
        .ram_dout       (ram_dout)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- SRAM model (1-cycle read latency) ----------------
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) begin
                for (int b = 0; b < XLEN_BYTES; b++) begin
                    if (ram_wem[b]) sram[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
                end
            end else begin
                ram_dout <= sram[ram_addr];
            end
        end
    end

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard: expected pushed at accept ----------------
    always @(posedge clk) begin
        if (rst) begin
            dropped += exp_q.size();
            exp_q.delete();
        end else if (dtcm_cmd_valid && dtcm_cmd_ready) begin
            acc_cnt++;
            acc_w = dtcm_cmd_addr[DTCM_ADDR_WIDTH-1:2];
            if (dtcm_cmd_read) begin
                exp_q.push_back(ref_mem[acc_w]);
            end else begin
                for (int b = 0; b < XLEN_BYTES; b++) begin
                    if (dtcm_cmd_wmask[b]) ref_mem[acc_w][8*b +: 8] = dtcm_cmd_wdata[8*b +: 8];
                end
                exp_q.push_back('0);
            end
        end
    end

    // ---------------- monitor: pops on every response beat ----------------
    always @(negedge clk) begin
        if (!rst && dtcm_rsp_valid && dtcm_rsp_ready) begin
            rsp_cnt++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rsp_unexpected: got response %h with no command pending", dtcm_rsp_rdata);
            end else begin
                check("rsp_data", dtcm_rsp_rdata, exp_q.pop_front());
            end
        end
    end

    // Buffer occupancy watch: a push into a full buffer would lose a response.
    always @(posedge clk) begin
        if (!rst) begin
            if (int'(dut.fcnt) > max_fcnt) max_fcnt = int'(dut.fcnt);
            if (dut.fifo_push && dut.fcnt == 2'd2) begin
                tests++;
                fails++;
                $display("FAIL fifo_overflow: push with count %0d required below 2", dut.fcnt);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) dtcm_rsp_ready = 1'($urandom_range(0, 1));
    endtask

    // Presents a command and returns one cycle after the accepting edge, valid left high.
    task automatic issue(input logic rd, input byte_addr_t addr, input word_t wd, input wmask_t wm);
        int budget = 200;
        dtcm_cmd_valid = 1'b1;
        dtcm_cmd_read  = rd;
        dtcm_cmd_addr  = addr;
        dtcm_cmd_wdata = wd;
        dtcm_cmd_wmask = wm;
        while (!dtcm_cmd_ready && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) check("cmd_accept_timeout", 32'(dtcm_cmd_ready), 32'd1);
        step();
    endtask

    task automatic idle();
        dtcm_cmd_valid = 1'b0;
        dtcm_cmd_read  = 1'b0;
        dtcm_cmd_wmask = '0;
    endtask

    task automatic drain();
        int budget = 200;
        while ((exp_q.size() != 0 || dtcm_rsp_valid) && budget > 0) begin
            step();
            budget--;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    int a0;
    int c0;

    initial begin
        rst            = 1'b1;
        dtcm_rsp_ready = 1'b1;
        dtcm_cmd_addr  = '0;
        dtcm_cmd_wdata = '0;
        idle();
        step();
        step();
        check("rst_cmd_ready", 32'(dtcm_cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(dtcm_rsp_valid), 32'd0);
        check("rst_rsp_rdata", dtcm_rsp_rdata, 32'd0);
        check("rst_ram_cs", 32'(ram_cs), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_cmd_ready", 32'(dtcm_cmd_ready), 32'd1);

        // Preload words 0..15 with a recognisable pattern.
        for (int i = 0; i < 16; i++) issue(1'b0, byte_addr_t'(i * 4), 32'hA500_0000 | i, 4'hF);
        idle();
        drain();

        // Full write then read-back: write response carries 0, read is bypassed at latency 1.
        issue(1'b0, 16'h0010, 32'hDEAD_BEEF, 4'hF);
        check("wr_rsp_valid", 32'(dtcm_rsp_valid), 32'd1);
        check("wr_rsp_rdata", dtcm_rsp_rdata, 32'd0);
        issue(1'b1, 16'h0010, 32'h0, 4'h0);
        check("rd_lat1_valid", 32'(dtcm_rsp_valid), 32'd1);
        check("rd_lat1_rdata", dtcm_rsp_rdata, 32'hDEAD_BEEF);
        idle();
        drain();

        // Byte-lane write merges into the existing word.
        issue(1'b0, 16'h0020, 32'h1122_3344, 4'hF);
        issue(1'b0, 16'h0020, 32'h0000_00AA, 4'b0001);
        issue(1'b1, 16'h0022, 32'h0, 4'h0);
        check("byte_merge_rdata", dtcm_rsp_rdata, 32'h1122_33AA);
        idle();
        drain();

        // Back-to-back reads: one accept per cycle, responses on consecutive cycles.
        c0 = cyc;
        issue(1'b1, 16'h0000, 32'h0, 4'h0);
        check("b2b_rdata0", dtcm_rsp_rdata, 32'hA500_0000);
        issue(1'b1, 16'h0004, 32'h0, 4'h0);
        check("b2b_rdata1", dtcm_rsp_rdata, 32'hA500_0001);
        issue(1'b1, 16'h0008, 32'h0, 4'h0);
        check("b2b_rdata2", dtcm_rsp_rdata, 32'hA500_0002);
        issue(1'b1, 16'h000C, 32'h0, 4'h0);
        check("b2b_rdata3", dtcm_rsp_rdata, 32'hA500_0003);
        check("b2b_cycles", 32'(cyc - c0), 32'd4);
        idle();
        drain();

        // Stall: two accepts, then credit exhausted with the head held stable.
        dtcm_rsp_ready = 1'b0;
        a0 = acc_cnt;
        dtcm_cmd_valid = 1'b1;
        dtcm_cmd_read  = 1'b1;
        dtcm_cmd_addr  = 16'h0030;
        for (int i = 0; i < 4; i++) step();
        check("stall_accepts", 32'(acc_cnt - a0), 32'd2);
        check("stall_cmd_ready", 32'(dtcm_cmd_ready), 32'd0);
        check("stall_rsp_valid", 32'(dtcm_rsp_valid), 32'd1);
        check("stall_rdata", dtcm_rsp_rdata, 32'hA500_000C);
        step();
        step();
        check("stall_rdata_stable", dtcm_rsp_rdata, 32'hA500_000C);
        check("stall_accepts_held", 32'(acc_cnt - a0), 32'd2);
        idle();
        dtcm_rsp_ready = 1'b1;
        #1;
        check("release_cmd_ready_pre_pop", 32'(dtcm_cmd_ready), 32'd0);
        step();
        check("release_cmd_ready_post_pop", 32'(dtcm_cmd_ready), 32'd1);
        check("release_second_valid", 32'(dtcm_rsp_valid), 32'd1);
        step();
        check("release_drained", 32'(dtcm_rsp_valid), 32'd0);

        // Reset with one response buffered and one in flight.
        dtcm_rsp_ready = 1'b0;
        dtcm_cmd_valid = 1'b1;
        dtcm_cmd_read  = 1'b1;
        dtcm_cmd_addr  = 16'h0034;
        step();
        step();
        idle();
        rst = 1'b1;
        #1;
        check("midrst_rsp_valid", 32'(dtcm_rsp_valid), 32'd0);
        check("midrst_cmd_ready", 32'(dtcm_cmd_ready), 32'd0);
        check("midrst_rdata", dtcm_rsp_rdata, 32'd0);
        step();
        step();
        rst = 1'b0;
        dtcm_rsp_ready = 1'b1;
        issue(1'b1, 16'h0010, 32'h0, 4'h0);
        check("after_rst_valid", 32'(dtcm_rsp_valid), 32'd1);
        check("after_rst_rdata", dtcm_rsp_rdata, 32'hDEAD_BEEF);
        idle();
        step();
        check("after_rst_no_stale", 32'(dtcm_rsp_valid), 32'd0);
        drain();

        // Random mix against the reference model under random back-pressure.
        rand_rdy = 1'b1;
        for (int n = 0; n < 200; n++) begin
            issue(1'($urandom_range(0, 1)), byte_addr_t'($urandom_range(0, 15) * 4),
                  word_t'($urandom), wmask_t'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) begin
                idle();
                step();
            end
        end
        idle();
        rand_rdy = 1'b0;
        dtcm_rsp_ready = 1'b1;
        drain();

        check("one_rsp_per_cmd", 32'(rsp_cnt + dropped), 32'(acc_cnt));
        check("fifo_max_le_2", 32'(max_fcnt <= 2), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
